// File: rtl/trng_word_reader.sv
// Packs the serial TRNG bit stream LSB-first into WORD_W-bit words and buffers them for a valid/ready host.
// Optional repetition-count health test is enabled with `define TRNG_RCT_EN.
module trng_word_reader #(
  parameter int WORD_W     = 16,
  parameter int DEPTH      = 4,
  parameter int RCT_CUTOFF = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bit_valid,
  input  logic              bit_in,
  input  logic              word_ready,
  output logic              word_valid,
  output logic [WORD_W-1:0] word,
  output logic [7:0]        drop_count,
  output logic              health_fail
);

  localparam int CNT_W = $clog2(WORD_W);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);
  localparam logic [PTR_W:0]   OCC_FULL = (PTR_W + 1)'(DEPTH);
  localparam logic [7:0]       CUTOFF   = 8'(RCT_CUTOFF);

  logic [CNT_W-1:0]  bit_cnt;
  logic [WORD_W-1:0] shift_reg;
  logic [WORD_W-1:0] assembled;
  logic [WORD_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    occ;
  logic              word_done;
  logic              fail_gate;
  logic              push_req;
  logic              push_ok;
  logic              pop;

  // The word offered to the FIFO already includes the bit accepted on this edge.
  always_comb begin
    assembled = shift_reg;
    assembled[bit_cnt] = bit_in;
  end

  assign word_done = bit_valid && (bit_cnt == LAST_BIT);
  assign push_req  = word_done && !fail_gate;
  assign pop       = word_valid && word_ready;
  assign push_ok   = push_req && ((occ < OCC_FULL) || pop);

  assign word_valid = (occ != '0);
  assign word       = word_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else if (bit_valid) begin
      if (word_done) begin
        bit_cnt   <= '0;
        shift_reg <= '0;
      end else begin
        bit_cnt   <= bit_cnt + 1'b1;
        shift_reg <= assembled;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= assembled;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      drop_count <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop) occ <= occ + 1'b1;
      else if (pop && !push_ok) occ <= occ - 1'b1;
      if (push_req && !push_ok && (drop_count != 8'hFF)) drop_count <= drop_count + 1'b1;
    end
  end

`ifdef TRNG_RCT_EN
  logic [7:0] run_cnt;
  logic [7:0] run_next;
  logic       last_bit;
  logic       fail_now;

  // run_cnt of 0 means no bit has been accepted since reset.
  always_comb begin
    if ((run_cnt != 8'd0) && (bit_in == last_bit))
      run_next = (run_cnt == 8'hFF) ? run_cnt : run_cnt + 8'd1;
    else
      run_next = 8'd1;
  end

  assign fail_now  = health_fail || (bit_valid && (run_next >= CUTOFF));
  assign fail_gate = fail_now;

  always_ff @(posedge clk) begin
    if (reset) begin
      run_cnt     <= 8'd0;
      last_bit    <= 1'b0;
      health_fail <= 1'b0;
    end else begin
      if (bit_valid) begin
        run_cnt  <= run_next;
        last_bit <= bit_in;
      end
      health_fail <= fail_now;
    end
  end
`else
  logic unused_cutoff;
  assign unused_cutoff = ^CUTOFF;
  assign fail_gate     = 1'b0;
  assign health_fail   = 1'b0;
`endif

endmodule

// File: tb/tb_trng_word_reader.sv
// Randomized and directed bench for trng_word_reader, checked against a queue-based word model.
module tb_trng_word_reader;

  localparam int WORD_W     = 16;
  localparam int DEPTH      = 4;
  localparam int RCT_CUTOFF = 32;

  logic              clk;
  logic              reset;
  logic              bit_valid;
  logic              bit_in;
  logic              word_ready;
  logic              word_valid;
  logic [WORD_W-1:0] word;
  logic [7:0]        drop_count;
  logic              health_fail;

  int errors = 0;
  int checks = 0;

  logic [31:0] mq[$];
  logic [31:0] part;
  int          nbits;
  int          mdrop;
  int          mrun;
  bit          mlast;
  bit          mfail;

  trng_word_reader #(.WORD_W(WORD_W), .DEPTH(DEPTH), .RCT_CUTOFF(RCT_CUTOFF)) dut (
    .clk(clk), .reset(reset), .bit_valid(bit_valid), .bit_in(bit_in),
    .word_ready(word_ready), .word_valid(word_valid), .word(word),
    .drop_count(drop_count), .health_fail(health_fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit v, input bit b, input bit rdy);
    if (r) begin
      mq.delete();
      part = 0; nbits = 0; mdrop = 0; mrun = 0; mlast = 0; mfail = 0;
    end else begin
      if (rdy && mq.size() > 0) void'(mq.pop_front());
      if (v) begin
`ifdef TRNG_RCT_EN
        if (mrun != 0 && b == mlast) mrun = (mrun < 255) ? mrun + 1 : 255;
        else mrun = 1;
        mlast = b;
        if (mrun >= RCT_CUTOFF) mfail = 1;
`endif
        part = part | (32'(b) << nbits);
        nbits++;
        if (nbits == WORD_W) begin
          if (!mfail) begin
            if (mq.size() < DEPTH) mq.push_back(part);
            else if (mdrop < 255) mdrop++;
          end
          part = 0;
          nbits = 0;
        end
      end
    end
  endtask

  task automatic cycle(input bit r, input bit v, input bit b, input bit rdy);
    reset = r; bit_valid = v; bit_in = b; word_ready = rdy;
    @(posedge clk);
    model_step(r, v, b, rdy);
    @(negedge clk);
    chk("word_valid", 32'(word_valid), (mq.size() != 0) ? 32'd1 : 32'd0);
    chk("word", 32'(word), (mq.size() != 0) ? mq[0] : 32'd0);
    chk("drop_count", 32'(drop_count), 32'(mdrop));
    chk("health_fail", 32'(health_fail), 32'(mfail));
  endtask

  initial begin
    logic [31:0] popped[$];
    reset = 1'b1; bit_valid = 1'b0; bit_in = 1'b0; word_ready = 1'b0;

    // Reset state
    cycle(1, 0, 0, 0);
    chk("rst_valid", 32'(word_valid), 32'd0);
    chk("rst_word", 32'(word), 32'd0);
    chk("rst_drop", 32'(drop_count), 32'd0);

    // Basic pack: 1 followed by fifteen 0s
    for (int i = 0; i < 16; i++) begin
      cycle(0, 1, (i == 0), 0);
      if (i == 14) chk("pack_not_early", 32'(word_valid), 32'd0);
    end
    chk("pack_valid", 32'(word_valid), 32'd1);
    chk("pack_word", 32'(word), 32'h0001);

    // Overflow: five alternating words into a 4-deep FIFO
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 5 * 16; i++) cycle(0, 1, ((i % 2) == 0), 0);
    chk("ovf_drop", 32'(drop_count), 32'd1);
    chk("ovf_word", 32'(word), 32'h5555);

    // Full FIFO, last bit of a word arrives with a pop
    for (int i = 0; i < 15; i++) cycle(0, 1, 1, 0);
    cycle(0, 1, 1, 1);
    chk("full_pp_drop", 32'(drop_count), 32'd1);
    popped.delete();
    for (int i = 0; i < 6; i++) begin
      if (word_valid) popped.push_back(32'(word));
      cycle(0, 0, 0, 1);
    end
    chk("full_pp_count", 32'(popped.size()), 32'd4);
    if (popped.size() == 4) begin
      chk("full_pp_head", popped[0], 32'h5555);
      chk("full_pp_tail", popped[3], 32'hFFFF);
    end

    // Reset mid-word
    for (int i = 0; i < 9; i++) cycle(0, 1, 1, 0);
    cycle(1, 1, 1, 1);
    for (int i = 0; i < 16; i++) cycle(0, 1, 0, 0);
    chk("midrst_valid", 32'(word_valid), 32'd1);
    chk("midrst_word", 32'(word), 32'h0000);
    chk("midrst_drop", 32'(drop_count), 32'd0);
    cycle(0, 0, 0, 1);
    chk("midrst_one", 32'(word_valid), 32'd0);

    // Gapped input: bit_valid toggles, 16 accepted ones
    for (int i = 0; i < 32; i++) begin
      cycle(0, ((i % 2) == 0), 1, 0);
      if (i == 29) chk("gap_not_early", 32'(word_valid), 32'd0);
    end
    chk("gap_word", 32'(word), 32'hFFFF);

`ifdef TRNG_RCT_EN
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 32; i++) begin
      cycle(0, 1, 1, 0);
      if (i == 30) chk("rct_not_early", 32'(health_fail), 32'd0);
    end
    chk("rct_fail", 32'(health_fail), 32'd1);
    chk("rct_drop", 32'(drop_count), 32'd0);
    for (int i = 0; i < 32; i++) cycle(0, 1, ((i % 2) == 0), 1);
    chk("rct_sticky", 32'(health_fail), 32'd1);
    cycle(1, 0, 0, 0);
    chk("rct_clear", 32'(health_fail), 32'd0);
`endif

    // Randomized traffic with varying host readiness and occasional resets
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      bit r, v, b, rdy;
      r   = ($urandom_range(0, 399) == 0);
      v   = ($urandom_range(0, 3) != 0);
      b   = 1'($urandom_range(0, 1));
      case (i / 1000)
        0:       rdy = ($urandom_range(0, 15) == 0);
        1:       rdy = ($urandom_range(0, 1) == 0);
        default: rdy = ($urandom_range(0, 7) != 0);
      endcase
      cycle(r, v, b, rdy);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
